// File: rtl/arbitro_ula.sv
// arbitro_ula: round-robin arbiter/sequencer sharing one external 8-bit ULA
// (add / sub / slt) between two requesters. A grant latches the winner's
// operation and operands, the ULA is driven for one cycle, its result and
// Zero flag are captured, and the winner receives a one-cycle pronto pulse.
module arbitro_ula (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       pronto0,
  output logic       pronto1,
  output logic [7:0] resultado,
  output logic       zero,
  output logic       ocupado,
  output logic [1:0] ULAOp,
  output logic [7:0] Dado1,
  output logic [7:0] Dado2,
  input  logic [7:0] SaidaULA,
  input  logic       Zero,
  output logic [7:0] contador_ops
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t    estado_q, estado_d;
  logic       prio_q, prio_d;
  logic       vencedor_q, vencedor_d;
  logic [1:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] resultado_q, resultado_d;
  logic       zero_q, zero_d;
  logic [7:0] contador_q, contador_d;
  logic       escolhido;

  // Next-state and output decode; the pointer only matters when both request.
  always_comb begin
    estado_d    = estado_q;
    prio_d      = prio_q;
    vencedor_d  = vencedor_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    resultado_d = resultado_q;
    zero_d      = zero_q;
    contador_d  = contador_q;
    escolhido   = 1'b0;
    pronto0     = 1'b0;
    pronto1     = 1'b0;
    ocupado     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (req0 || req1) begin
          escolhido  = (req0 && req1) ? prio_q : req1;
          vencedor_d = escolhido;
          op_d       = escolhido ? op1 : op0;
          a_d        = escolhido ? a1  : a0;
          b_d        = escolhido ? b1  : b0;
          estado_d   = EXECUTA;
        end
      end
      EXECUTA: begin
        ocupado     = 1'b1;
        resultado_d = SaidaULA;
        zero_d      = Zero;
        estado_d    = RESPOSTA;
      end
      RESPOSTA: begin
        ocupado    = 1'b1;
        pronto0    = ~vencedor_q;
        pronto1    = vencedor_q;
        prio_d     = ~vencedor_q;
        contador_d = contador_q + 8'd1;
        estado_d   = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State, latched request and captured result; reset aborts any operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= OCIOSO;
      prio_q      <= 1'b0;
      vencedor_q  <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      resultado_q <= 8'd0;
      zero_q      <= 1'b0;
      contador_q  <= 8'd0;
    end else begin
      estado_q    <= estado_d;
      prio_q      <= prio_d;
      vencedor_q  <= vencedor_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      resultado_q <= resultado_d;
      zero_q      <= zero_d;
      contador_q  <= contador_d;
    end
  end

  assign ULAOp        = op_q;
  assign Dado1        = a_q;
  assign Dado2        = b_q;
  assign resultado    = resultado_q;
  assign zero         = zero_q;
  assign contador_ops = contador_q;

endmodule
